// File: rtl/instr_fetch_queue_pkg.sv
// instr_fetch_queue_pkg: shared fetch constants and the slot layout.
package instr_fetch_queue_pkg;
    localparam int XLEN = 32;
    localparam int DEFAULT_DEPTH = 4;
    localparam logic [XLEN-1:0] FETCH_NOP = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } slot_t;
endpackage

// File: rtl/fetch_slot_queue.sv
// fetch_slot_queue: in-order slot ring with separate tail (alloc), fill and head (pop) pointers.
module fetch_slot_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            alloc,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill,
    input  logic [XLEN-1:0] fill_instr,
    input  logic            pop,
    output logic            head_filled,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_instr,
    output logic [AW:0]     alloc_cnt,
    output logic [AW:0]     fill_cnt
);
    slot_t         slots_q [DEPTH];
    slot_t         slots_d [DEPTH];
    logic [AW-1:0] head_q, head_d, fill_ptr_q, fill_ptr_d, tail_q, tail_d;
    logic [AW:0]   alloc_cnt_q, alloc_cnt_d, fill_cnt_q, fill_cnt_d;

    always_comb begin
        slots_d     = slots_q;
        head_d      = head_q;
        fill_ptr_d  = fill_ptr_q;
        tail_d      = tail_q;
        alloc_cnt_d = alloc_cnt_q;
        fill_cnt_d  = fill_cnt_q;
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) slots_d[i].filled = 1'b0;
            head_d      = '0;
            fill_ptr_d  = '0;
            tail_d      = '0;
            alloc_cnt_d = '0;
            fill_cnt_d  = '0;
        end else begin
            if (alloc) begin
                slots_d[tail_q].pc     = alloc_pc;
                slots_d[tail_q].filled = 1'b0;
                tail_d                 = tail_q + 1'b1;
            end
            if (fill) begin
                slots_d[fill_ptr_q].instr  = fill_instr;
                slots_d[fill_ptr_q].filled = 1'b1;
                fill_ptr_d                 = fill_ptr_q + 1'b1;
            end
            if (pop) begin
                slots_d[head_q].filled = 1'b0;
                head_d                 = head_q + 1'b1;
            end
            alloc_cnt_d = alloc_cnt_q + (AW+1)'(alloc) - (AW+1)'(pop);
            fill_cnt_d  = fill_cnt_q + (AW+1)'(fill) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots_q     <= '{default: '0};
            head_q      <= '0;
            fill_ptr_q  <= '0;
            tail_q      <= '0;
            alloc_cnt_q <= '0;
            fill_cnt_q  <= '0;
        end else begin
            slots_q     <= slots_d;
            head_q      <= head_d;
            fill_ptr_q  <= fill_ptr_d;
            tail_q      <= tail_d;
            alloc_cnt_q <= alloc_cnt_d;
            fill_cnt_q  <= fill_cnt_d;
        end
    end

    assign head_filled = slots_q[head_q].filled;
    assign head_pc     = slots_q[head_q].pc;
    assign head_instr  = slots_q[head_q].instr;
    assign alloc_cnt   = alloc_cnt_q;
    assign fill_cnt    = fill_cnt_q;
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: issues PC_F to imem, buffers in-order responses for decode, kills wrong-path fetches on flush.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int              DEPTH     = DEFAULT_DEPTH,
    parameter logic [XLEN-1:0] NOP_INSTR = FETCH_NOP
) (
    input  logic            CLK,
    input  logic            RESETn,
    input  logic [XLEN-1:0] PC_F,
    output logic            StallF,
    input  logic            FlushF,
    output logic            IMEM_REQ,
    output logic [XLEN-1:0] IMEM_ADDR,
    input  logic            IMEM_GNT,
    input  logic            IMEM_RVALID,
    input  logic [XLEN-1:0] IMEM_RDATA,
    output logic            ValidD,
    input  logic            ReadyD,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD
);
    localparam int AW = $clog2(DEPTH);
    // Headroom above DEPTH: back-to-back flushes can stack kills from several generations.
    localparam int KW = AW + 2;

    logic [AW:0]     alloc_cnt, fill_cnt, outstanding;
    logic [KW-1:0]   kill_cnt_q, kill_cnt_d;
    logic [XLEN-1:0] pcd_q, pcd_d, head_pc, head_instr;
    logic            head_filled, grant, fill, pop;

    fetch_slot_queue #(.DEPTH(DEPTH)) u_slots (
        .clk        (CLK),
        .rst_n      (RESETn),
        .clear      (FlushF),
        .alloc      (grant),
        .alloc_pc   (PC_F),
        .fill       (fill),
        .fill_instr (IMEM_RDATA),
        .pop        (pop),
        .head_filled(head_filled),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .alloc_cnt  (alloc_cnt),
        .fill_cnt   (fill_cnt)
    );

    always_comb begin
        outstanding = alloc_cnt - fill_cnt;
        IMEM_REQ    = RESETn & ~FlushF & (alloc_cnt != (AW+1)'(DEPTH));
        IMEM_ADDR   = PC_F;
        grant       = IMEM_REQ & IMEM_GNT;
        StallF      = ~RESETn | (~FlushF & ~grant);
        fill        = IMEM_RVALID & ~FlushF & (kill_cnt_q == '0) & (outstanding != '0);
        ValidD      = head_filled;
        pop         = ValidD & ReadyD & ~FlushF;
        InstrD      = ValidD ? head_instr : NOP_INSTR;
        PCD         = ValidD ? head_pc : pcd_q;
        pcd_d       = PCD;
        // A response in the flush cycle belongs to the wrong path and retires one kill immediately.
        kill_cnt_d  = FlushF
            ? kill_cnt_q + KW'(outstanding) - KW'(IMEM_RVALID && (kill_cnt_q != '0 || outstanding != '0))
            : kill_cnt_q - KW'(IMEM_RVALID && kill_cnt_q != '0);
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            kill_cnt_q <= '0;
            pcd_q      <= '0;
        end else begin
            kill_cnt_q <= kill_cnt_d;
            pcd_q      <= pcd_d;
        end
    end

    a_rvalid_expected: assert property (@(posedge CLK) disable iff (!RESETn)
        !(IMEM_RVALID && kill_cnt_q == '0 && outstanding == '0));
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: randomized scoreboard bench with an in-order memory model and a fetch-stream reference.
module tb_instr_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] KEY   = 32'hA5A5A5A5;

    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct { logic [31:0] pc; int rdy; } mem_t;

    logic        CLK = 0, RESETn = 0, FlushF = 0, IMEM_GNT = 0, IMEM_RVALID = 0, ReadyD = 0;
    logic [31:0] PC_F = 32'h00400000, IMEM_RDATA = 0;
    logic        StallF, IMEM_REQ, ValidD;
    logic [31:0] IMEM_ADDR, InstrD, PCD;

    exp_t        exp_q[$];
    mem_t        mem_q[$];
    int          checks = 0, errors = 0, cyc = 0, live = 0, dut_grants = 0;
    logic [31:0] pc = 32'h00400000, last_pcd = 0, hold_addr;
    bit          prev_flush = 0;

    instr_fetch_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .CLK(CLK), .RESETn(RESETn), .PC_F(PC_F), .StallF(StallF), .FlushF(FlushF),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
        .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
        .ValidD(ValidD), .ReadyD(ReadyD), .InstrD(InstrD), .PCD(PCD)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chkb(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // One clock of stimulus; percentages steer flush, grant, ready and response probability.
    task automatic cycle(input int pf, input int pg, input int pr, input int pv,
                         input logic [31:0] target = 32'h00400100);
        bit   exp_req, g;
        exp_t e;
        mem_t m;
        @(posedge CLK);
        #1;
        cyc++;
        FlushF      = RESETn && ($urandom_range(99) < pf);
        IMEM_GNT    = ($urandom_range(99) < pg) && (mem_q.size() < 12);
        ReadyD      = $urandom_range(99) < pr;
        PC_F        = pc;
        IMEM_RVALID = 0;
        IMEM_RDATA  = $urandom;
        if (mem_q.size() > 0 && mem_q[0].rdy <= cyc && $urandom_range(99) < pv) begin
            IMEM_RVALID = 1;
            IMEM_RDATA  = mem_q[0].pc ^ KEY;
            void'(mem_q.pop_front());
        end
        #3;
        exp_req = RESETn && !FlushF && live < DEPTH;
        g       = exp_req && IMEM_GNT;
        chkb("imem_req", IMEM_REQ, exp_req);
        chkb("stallf", StallF, !RESETn || (!FlushF && !g));
        chk("imem_addr", IMEM_ADDR, PC_F);
        if (IMEM_REQ && IMEM_GNT) dut_grants++;
        if (RESETn && FlushF) begin
            live = 0;
            pc   = target;
        end else if (RESETn) begin
            if (g) begin
                e.pc = pc; e.instr = pc ^ KEY; exp_q.push_back(e);
                m.pc = pc; m.rdy = cyc + 1; mem_q.push_back(m);
                pc += 4;
            end
            live += int'(g) - int'(ValidD && ReadyD);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || mem_q.size() != 0) && n < 200) begin
            cycle(0, 0, 100, 100);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || mem_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries and %0d responses pending, expected none", exp_q.size(), mem_q.size());
        end
    endtask

    // Monitor: compares the presented head against the scoreboard and retires it on a pop.
    always @(negedge CLK) begin
        if (!RESETn) last_pcd = 0;
        if (prev_flush) chkb("valid_after_flush", ValidD, 1'b0);
        if (ValidD) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_valid: got PCD %h expected no entry (cycle %0d)", PCD, cyc);
            end else begin
                chk("pcd", PCD, exp_q[0].pc);
                chk("instrd", InstrD, exp_q[0].instr);
                last_pcd = exp_q[0].pc;
                if (ReadyD && !FlushF) void'(exp_q.pop_front());
            end
        end else begin
            chk("instrd_nop", InstrD, NOP);
            chk("pcd_hold", PCD, last_pcd);
        end
        if (FlushF) exp_q.delete();
        prev_flush = RESETn && FlushF;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish by 1000000");
        $fatal(1);
    end

    initial begin
        repeat (3) cycle(0, 0, 0, 0);
        chkb("rst_valid", ValidD, 1'b0);
        chk("rst_pcd", PCD, 32'h0);
        @(negedge CLK);
        #2 RESETn = 1;
        cyc = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle(0, 100, 100, 100);
            if (k <= 3) chkb("first_valid", ValidD, k == 3);
            if (k == 3) chk("first_pcd", PCD, 32'h00400000);
        end
        drain();
        dut_grants = 0;
        repeat (10) cycle(0, 100, 0, 100);
        chk("full_grants", dut_grants, 4);
        chkb("full_req", IMEM_REQ, 1'b0);
        repeat (10) cycle(0, 100, 100, 100);
        drain();
        repeat (2) cycle(0, 100, 100, 0);
        cycle(100, 0, 100, 0, 32'h00400100);
        repeat (10) cycle(0, 100, 100, 100);
        drain();
        cycle(0, 100, 0, 0);
        cycle(0, 100, 0, 100);
        cycle(0, 100, 0, 0);
        chkb("pre_flush_valid", ValidD, 1'b1);
        cycle(100, 0, 100, 100, 32'h00400200);
        repeat (8) cycle(0, 100, 100, 100);
        drain();
        hold_addr = pc;
        repeat (5) begin
            cycle(0, 0, 100, 100);
            chkb("gntlow_req", IMEM_REQ, 1'b1);
            chkb("gntlow_stall", StallF, 1'b1);
            chk("gntlow_addr", IMEM_ADDR, hold_addr);
        end
        repeat (2000) cycle(5, 70, 70, 70, 32'h00400000 + ($urandom_range(1023) << 2));
        drain();
        repeat (2) cycle(0, 100, 100, 0);
        @(posedge CLK);
        #1;
        RESETn = 0; FlushF = 0; IMEM_GNT = 0; IMEM_RVALID = 0; ReadyD = 0;
        #1;
        chkb("midrst_valid", ValidD, 1'b0);
        chkb("midrst_req", IMEM_REQ, 1'b0);
        chkb("midrst_stall", StallF, 1'b1);
        chk("midrst_instr", InstrD, NOP);
        chk("midrst_pcd", PCD, 32'h0);
        exp_q.delete();
        mem_q.delete();
        live = 0;
        pc   = 32'h00400000;
        repeat (2) cycle(0, 0, 0, 0);
        @(negedge CLK);
        #2 RESETn = 1;
        repeat (300) cycle(5, 70, 70, 70, 32'h00400000 + ($urandom_range(1023) << 2));
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
